// File: rtl/adc_start_pulse_gen.sv
// Per-channel start_conv edge detector producing counter-timed ena_out pulses with hold-off and overrun flagging.
// Optional input synchronizer is compiled in with `define ADC_START_SYNC_EN.
module adc_start_pulse_gen #(
  parameter int NCH         = 1,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   start_conv,
  input  logic [CNT_W-1:0] pulse_len,
  input  logic [CNT_W-1:0] holdoff_len,
  input  logic             clr_overrun,
  output logic [NCH-1:0]   ena_out,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state [NCH];
  logic [CNT_W-1:0] cnt   [NCH];
  logic [NCH-1:0]   s_p0;
  logic [NCH-1:0]   prev_p0;
  logic [NCH-1:0]   rise_p1;

  // A zero pulse length still yields a one-cycle pulse.
  function automatic logic [CNT_W-1:0] pulse_load(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_ONE;
  endfunction

  function automatic logic [CNT_W-1:0] holdoff_load(input logic [CNT_W-1:0] len);
    return len - CNT_ONE;
  endfunction

  if (SYNC_STAGES < 2) begin : g_sync_stages_check
    $error("adc_start_pulse_gen: SYNC_STAGES must be at least 2");
  end

`ifdef ADC_START_SYNC_EN
  logic [SYNC_STAGES-1:0] sync_q [NCH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst) sync_q[i] <= '0;
      else     sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], start_conv[i]};
    end
  end

  always_comb begin
    s_p0 = '0;
    for (int i = 0; i < NCH; i++) s_p0[i] = sync_q[i][SYNC_STAGES-1];
  end
`else
  assign s_p0 = start_conv;
`endif

  // Stage p0 -> p1: edge detect, registered so the FSM sees a clean one-cycle rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_p0 <= '0;
      rise_p1 <= '0;
    end else begin
      prev_p0 <= s_p0;
      rise_p1 <= s_p0 & ~prev_p0;
    end
  end

  // Stage p1 -> outputs: per-channel FSM with registered ena_out/busy/overrun.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        state[i]   <= IDLE;
        cnt[i]     <= '0;
        ena_out[i] <= 1'b0;
        busy[i]    <= 1'b0;
        overrun[i] <= 1'b0;
      end else begin
        overrun[i] <= (overrun[i] & ~clr_overrun) | (rise_p1[i] & (state[i] != IDLE));
        case (state[i])
          IDLE: begin
            if (rise_p1[i]) begin
              state[i]   <= PULSE;
              cnt[i]     <= pulse_load(pulse_len);
              ena_out[i] <= 1'b1;
              busy[i]    <= 1'b1;
            end
          end
          PULSE: begin
            if (cnt[i] != '0) begin
              cnt[i] <= cnt[i] - CNT_ONE;
            end else if (holdoff_len != '0) begin
              state[i]   <= HOLDOFF;
              cnt[i]     <= holdoff_load(holdoff_len);
              ena_out[i] <= 1'b0;
            end else begin
              state[i]   <= IDLE;
              ena_out[i] <= 1'b0;
              busy[i]    <= 1'b0;
            end
          end
          HOLDOFF: begin
            if (cnt[i] != '0) begin
              cnt[i] <= cnt[i] - CNT_ONE;
            end else begin
              state[i] <= IDLE;
              busy[i]  <= 1'b0;
            end
          end
          default: begin
            state[i]   <= IDLE;
            cnt[i]     <= '0;
            ena_out[i] <= 1'b0;
            busy[i]    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_start_pulse_gen.sv
// Directed scoreboard bench for adc_start_pulse_gen (NCH=4); latency follows ADC_START_SYNC_EN.
module tb_adc_start_pulse_gen;
  localparam int NCH   = 4;
  localparam int CNT_W = 8;
  localparam int SS    = 2;
`ifdef ADC_START_SYNC_EN
  localparam int LAT = SS + 1;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   start_conv;
  logic [CNT_W-1:0] pulse_len;
  logic [CNT_W-1:0] holdoff_len;
  logic             clr_overrun;
  logic [NCH-1:0]   ena_out;
  logic [NCH-1:0]   busy;
  logic [NCH-1:0]   overrun;

  always #5 clk = ~clk;

  adc_start_pulse_gen #(.NCH(NCH), .CNT_W(CNT_W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .start_conv(start_conv), .pulse_len(pulse_len),
    .holdoff_len(holdoff_len), .clr_overrun(clr_overrun),
    .ena_out(ena_out), .busy(busy), .overrun(overrun)
  );

  typedef struct packed {
    logic [NCH-1:0] ena;
    logic [NCH-1:0] bsy;
    logic [NCH-1:0] ovr;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  function automatic logic in_win(input int k, input int st, input int len);
    return (st >= 0) && (k >= st) && (k < st + len);
  endfunction

  // Expected per-cycle outputs for a window; k counts edges from the one that first samples start_conv.
  task automatic plan(input int n, input logic [NCH-1:0] mask, input int st1, input int st2,
                      input int p, input int h, input int ovr_from, input logic [NCH-1:0] ovr_base);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.ena = (in_win(k, st1, p) || in_win(k, st2, p)) ? mask : '0;
      e.bsy = (in_win(k, st1, p + h) || in_win(k, st2, p + h)) ? mask : '0;
      e.ovr = ovr_base | (((ovr_from >= 0) && (k >= ovr_from)) ? mask : '0);
      q.push_back(e);
    end
  endtask

  task automatic chk(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_underflow cycle=%0d observed=empty expected=entry", cyc);
    end else begin
      e = q.pop_front();
      chk("ena_out", ena_out, e.ena);
      chk("busy", busy, e.bsy);
      chk("overrun", overrun, e.ovr);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; start_conv = '0; pulse_len = 8'd4; holdoff_len = '0; clr_overrun = 1'b0;

    // Reset state
    plan(3, '0, -1, -1, 0, 0, -1, '0);
    ticks(3);
    rst = 1'b0;
    plan(2, '0, -1, -1, 0, 0, -1, '0);
    ticks(2);

    // pulse_len=4, no hold-off; a mid-pulse pulse_len change must not matter
    plan(LAT + 6, 4'b0001, LAT, -1, 4, 0, -1, '0);
    start_conv = 4'b0001; ticks(LAT + 1);
    pulse_len = 8'd1; start_conv = '0; ticks(5);

    // pulse_len=0 -> one cycle
    pulse_len = 8'd0;
    plan(LAT + 3, 4'b0001, LAT, -1, 1, 0, -1, '0);
    start_conv = 4'b0001; ticks(1);
    start_conv = '0; ticks(LAT + 2);

    // pulse_len=255 -> 255 cycles
    pulse_len = 8'd255;
    plan(LAT + 257, 4'b0001, LAT, -1, 255, 0, -1, '0);
    start_conv = 4'b0001; ticks(1);
    start_conv = '0; ticks(LAT + 256);

    // Minimum spacing: rise arriving in the first idle cycle is accepted
    pulse_len = 8'd2; holdoff_len = 8'd3;
    plan(LAT + 12, 4'b0001, LAT, LAT + 6, 2, 3, -1, '0);
    start_conv = 4'b0001; ticks(1);
    start_conv = '0; ticks(5);
    start_conv = 4'b0001; ticks(1);
    start_conv = '0; ticks(LAT + 5);

    // Rise in the 3rd busy cycle -> discarded, overrun set
    plan(LAT + 7, 4'b0001, LAT, -1, 2, 3, LAT + 3, '0);
    start_conv = 4'b0001; ticks(1);
    start_conv = '0; ticks(2);
    start_conv = 4'b0001; ticks(1);
    start_conv = '0; ticks(LAT + 3);

    // Clear coinciding with a rise in HOLDOFF -> set wins
    plan(LAT + 7, 4'b0001, LAT, -1, 2, 3, -1, 4'b0001);
    start_conv = 4'b0001; ticks(1);
    start_conv = '0; ticks(2);
    start_conv = 4'b0001; ticks(1);
    start_conv = '0; ticks(LAT - 1);
    clr_overrun = 1'b1; ticks(1);
    clr_overrun = 1'b0; ticks(3);

    // Plain clear
    plan(2, 4'b0001, -1, -1, 0, 0, -1, '0);
    clr_overrun = 1'b1; ticks(1);
    clr_overrun = 1'b0; ticks(1);

    // Rise in the last HOLDOFF cycle -> discarded, overrun set
    plan(LAT + 8, 4'b0001, LAT, -1, 2, 3, LAT + 5, '0);
    start_conv = 4'b0001; ticks(1);
    start_conv = '0; ticks(4);
    start_conv = 4'b0001; ticks(1);
    start_conv = '0; ticks(LAT + 2);
    plan(1, 4'b0001, -1, -1, 0, 0, -1, '0);
    clr_overrun = 1'b1; ticks(1);
    clr_overrun = 1'b0;

    // Concurrent edges on channels 0 and 2
    pulse_len = 8'd3; holdoff_len = '0;
    plan(LAT + 4, 4'b0101, LAT, -1, 3, 0, -1, '0);
    start_conv = 4'b0101; ticks(1);
    start_conv = '0; ticks(LAT + 3);

    // Reset in the 2nd cycle of a 5-cycle pulse, input held high through release
    pulse_len = 8'd5;
    plan(LAT + 2, 4'b0001, LAT, -1, 5, 0, -1, '0);
    start_conv = 4'b0001; ticks(LAT + 2);
    rst = 1'b1;
    plan(2, '0, -1, -1, 0, 0, -1, '0);
    ticks(2);
    rst = 1'b0;
    plan(LAT + 8, 4'b0001, LAT, -1, 5, 0, -1, '0);
    ticks(LAT + 8);
    start_conv = '0;
    plan(LAT + 2, '0, -1, -1, 0, 0, -1, '0);
    ticks(LAT + 2);

    checks++;
    assert (q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
